// File: rtl/tap_controller.sv
// IEEE 1149.1 TAP controller with a 4-bit instruction register.
// Decodes IR into one-hot selects and muxes serial data onto TDO.
module tap_controller #(
    parameter int             IR_W        = 4,
    parameter logic [IR_W-1:0] OP_EXTEST   = 4'h0,
    parameter logic [IR_W-1:0] OP_SAMPLE   = 4'h1,
    parameter logic [IR_W-1:0] OP_IDCODE   = 4'h2,
    parameter logic [IR_W-1:0] OP_INTEST   = 4'h3,
    parameter logic [IR_W-1:0] OP_USERCODE = 4'h4,
    parameter logic [IR_W-1:0] OP_RUNBIST  = 4'h5,
    parameter logic [IR_W-1:0] IR_CAPT     = 4'b0101
) (
    input  logic       TCK,
    input  logic       RESET,
    input  logic       TMS,
    input  logic       TDI,
    input  logic       ID_REG_TDO,
    input  logic       BSR_TDO,
    output logic       TDO,
    output logic       TDO_EN,
    output logic       CAPTUREDR,
    output logic       SHIFTDR,
    output logic       UPDATEDR,
    output logic       IDCODE_SELECT,
    output logic       SAMPLE_SELECT,
    output logic       EXTEST_SELECT,
    output logic       INTEST_SELECT,
    output logic       USERCODE_SELECT,
    output logic       RUNBIST_SELECT,
    output logic       BYPASS_SELECT,
    output logic       BIST_START,
    output logic [3:0] TAP_STATE
);

    typedef enum logic [3:0] {
        EX2DR = 4'h0,
        EX1DR = 4'h1,
        SHDR  = 4'h2,
        PAUDR = 4'h3,
        SELIR = 4'h4,
        UPDDR = 4'h5,
        CAPDR = 4'h6,
        SELDR = 4'h7,
        EX2IR = 4'h8,
        EX1IR = 4'h9,
        SHIR  = 4'hA,
        PAUIR = 4'hB,
        RTI   = 4'hC,
        UPDIR = 4'hD,
        CAPIR = 4'hE,
        TLR   = 4'hF
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [IR_W-1:0]   ir_q;
    logic [IR_W-1:0]   ir_d;
    logic [IR_W-1:0]   ir_sr_q;
    logic              bypass_q;
    logic              bist_q;
    logic              tdo_ir_q;
    logic              tdo_byp_q;
    logic              in_upd;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            TLR:   state_d = TMS ? TLR   : RTI;
            RTI:   state_d = TMS ? SELDR : RTI;
            SELDR: state_d = TMS ? SELIR : CAPDR;
            SELIR: state_d = TMS ? TLR   : CAPIR;
            CAPDR: state_d = TMS ? EX1DR : SHDR;
            SHDR:  state_d = TMS ? EX1DR : SHDR;
            EX1DR: state_d = TMS ? UPDDR : PAUDR;
            PAUDR: state_d = TMS ? EX2DR : PAUDR;
            EX2DR: state_d = TMS ? UPDDR : SHDR;
            UPDDR: state_d = TMS ? SELDR : RTI;
            CAPIR: state_d = TMS ? EX1IR : SHIR;
            SHIR:  state_d = TMS ? EX1IR : SHIR;
            EX1IR: state_d = TMS ? UPDIR : PAUIR;
            PAUIR: state_d = TMS ? EX2IR : PAUIR;
            EX2IR: state_d = TMS ? UPDIR : SHIR;
            UPDIR: state_d = TMS ? SELDR : RTI;
            default: state_d = TLR;
        endcase
    end

    // IR value after this edge; BIST_START keys off it so the pulse
    // lines up with the newly selected instruction.
    always_comb begin
        ir_d = ir_q;
        if (state_q == UPDIR) ir_d = ir_sr_q;
        if (state_q == TLR)   ir_d = OP_IDCODE;
    end

    assign in_upd = (state_q == UPDIR) || (state_q == UPDDR);

    always_ff @(posedge TCK) begin
        if (RESET) begin
            state_q  <= TLR;
            ir_q     <= OP_IDCODE;
            ir_sr_q  <= '0;
            bypass_q <= 1'b0;
            bist_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            bist_q  <= in_upd && (state_d == RTI) &&
                       (ir_d == OP_RUNBIST);
            if (state_q == CAPIR)
                ir_sr_q <= IR_CAPT;
            else if (state_q == SHIR)
                ir_sr_q <= {TDI, ir_sr_q[IR_W-1:1]};
            if (state_q == CAPDR)
                bypass_q <= 1'b0;
            else if (state_q == SHDR && BYPASS_SELECT)
                bypass_q <= TDI;
        end
    end

    // Half-cycle retiming to line up with dr's negedge TDO.
    always_ff @(negedge TCK) begin
        tdo_ir_q  <= ir_sr_q[0];
        tdo_byp_q <= bypass_q;
    end

    always_comb begin
        EXTEST_SELECT   = 1'b0;
        SAMPLE_SELECT   = 1'b0;
        IDCODE_SELECT   = 1'b0;
        INTEST_SELECT   = 1'b0;
        USERCODE_SELECT = 1'b0;
        RUNBIST_SELECT  = 1'b0;
        BYPASS_SELECT   = 1'b0;
        unique case (1'b1)
            (ir_q == OP_EXTEST):   EXTEST_SELECT   = 1'b1;
            (ir_q == OP_SAMPLE):   SAMPLE_SELECT   = 1'b1;
            (ir_q == OP_IDCODE):   IDCODE_SELECT   = 1'b1;
            (ir_q == OP_INTEST):   INTEST_SELECT   = 1'b1;
            (ir_q == OP_USERCODE): USERCODE_SELECT = 1'b1;
            (ir_q == OP_RUNBIST):  RUNBIST_SELECT  = 1'b1;
            default:               BYPASS_SELECT   = 1'b1;
        endcase
    end

    always_comb begin
        TDO    = 1'b0;
        TDO_EN = 1'b0;
        if (state_q == SHIR) begin
            TDO    = tdo_ir_q;
            TDO_EN = 1'b1;
        end else if (state_q == SHDR) begin
            TDO_EN = 1'b1;
            if (IDCODE_SELECT)
                TDO = ID_REG_TDO;
            else if (BYPASS_SELECT)
                TDO = tdo_byp_q;
            else
                TDO = BSR_TDO;
        end
    end

    assign CAPTUREDR  = (state_q == CAPDR);
    assign SHIFTDR    = (state_q == SHDR);
    assign UPDATEDR   = (state_q == UPDDR);
    assign BIST_START = bist_q;
    assign TAP_STATE  = state_q;

endmodule

// File: tb/tb_tap_controller.sv
// Randomised bench for tap_controller against a table-driven TAP model.
// Directed scans first, then a long random TMS/TDI/RESET walk.
module tb_tap_controller;

    logic       TCK = 1'b0;
    logic       RESET = 1'b1;
    logic       TMS = 1'b0;
    logic       TDI = 1'b0;
    logic       ID_REG_TDO = 1'b0;
    logic       BSR_TDO = 1'b0;
    logic       TDO, TDO_EN, CAPTUREDR, SHIFTDR, UPDATEDR;
    logic       IDCODE_SELECT, SAMPLE_SELECT, EXTEST_SELECT;
    logic       INTEST_SELECT, USERCODE_SELECT, RUNBIST_SELECT;
    logic       BYPASS_SELECT, BIST_START;
    logic [3:0] TAP_STATE;

    tap_controller dut (
        .TCK(TCK), .RESET(RESET), .TMS(TMS), .TDI(TDI),
        .ID_REG_TDO(ID_REG_TDO), .BSR_TDO(BSR_TDO),
        .TDO(TDO), .TDO_EN(TDO_EN),
        .CAPTUREDR(CAPTUREDR), .SHIFTDR(SHIFTDR),
        .UPDATEDR(UPDATEDR),
        .IDCODE_SELECT(IDCODE_SELECT),
        .SAMPLE_SELECT(SAMPLE_SELECT),
        .EXTEST_SELECT(EXTEST_SELECT),
        .INTEST_SELECT(INTEST_SELECT),
        .USERCODE_SELECT(USERCODE_SELECT),
        .RUNBIST_SELECT(RUNBIST_SELECT),
        .BYPASS_SELECT(BYPASS_SELECT),
        .BIST_START(BIST_START), .TAP_STATE(TAP_STATE)
    );

    always #5 TCK = ~TCK;

    // next state indexed by state code, for TMS=1 and TMS=0
    int t1 [16] = '{5, 5, 1, 0, 15, 7, 1, 4,
                    13, 13, 9, 8, 7, 7, 9, 15};
    int t0 [16] = '{2, 3, 2, 3, 14, 12, 2, 6,
                    10, 11, 10, 11, 12, 12, 10, 12};

    int m_state = 15;
    int m_ir = 2;
    int m_sr = 0;
    int m_byp = 0;
    int m_bist = 0;
    int m_tdo_ir = 0;
    int m_tdo_byp = 0;
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag,
                       input int unsigned got,
                       input int unsigned exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     tag, got, exp, $time);
        end
    endtask

    task automatic model_pos(input logic rst, tms, tdi);
        int nxt;
        int ir_new;
        if (rst) begin
            m_state = 15; m_ir = 2; m_sr = 0;
            m_byp = 0; m_bist = 0;
            return;
        end
        nxt = tms ? t1[m_state] : t0[m_state];
        ir_new = m_ir;
        if (m_state == 13) ir_new = m_sr;
        if (m_state == 15) ir_new = 2;
        m_bist = ((m_state == 13 || m_state == 5) &&
                  nxt == 12 && ir_new == 5) ? 1 : 0;
        if (m_state == 14) m_sr = 5;
        if (m_state == 10) m_sr = (m_sr >> 1) | (int'(tdi) << 3);
        if (m_state == 6) m_byp = 0;
        if (m_state == 2 && m_ir > 5) m_byp = int'(tdi);
        m_ir = ir_new;
        m_state = nxt;
    endtask

    task automatic compare();
        int exp_tdo;
        logic [6:0] sel;
        int idx;
        sel = {BYPASS_SELECT, RUNBIST_SELECT, USERCODE_SELECT,
               INTEST_SELECT, IDCODE_SELECT, SAMPLE_SELECT,
               EXTEST_SELECT};
        idx = (m_ir <= 5) ? m_ir : 6;
        exp_tdo = 0;
        if (m_state == 10) exp_tdo = m_tdo_ir;
        else if (m_state == 2) begin
            if (m_ir == 2) exp_tdo = int'(ID_REG_TDO);
            else if (m_ir > 5) exp_tdo = m_tdo_byp;
            else exp_tdo = int'(BSR_TDO);
        end
        chk("state", TAP_STATE, m_state);
        chk("select", sel, 1 << idx);
        chk("capturedr", CAPTUREDR, m_state == 6);
        chk("shiftdr", SHIFTDR, m_state == 2);
        chk("updatedr", UPDATEDR, m_state == 5);
        chk("tdo_en", TDO_EN, m_state == 2 || m_state == 10);
        chk("tdo", TDO, exp_tdo);
        chk("bist_start", BIST_START, m_bist);
    endtask

    task automatic step(input logic rst, tms, tdi);
        RESET = rst; TMS = tms; TDI = tdi;
        ID_REG_TDO = 1'($urandom_range(0, 1));
        BSR_TDO = 1'($urandom_range(0, 1));
        @(posedge TCK);
        model_pos(rst, tms, tdi);
        @(negedge TCK);
        m_tdo_ir = m_sr & 1;
        m_tdo_byp = m_byp;
        #1;
        compare();
    endtask

    task automatic tms_seq(input int n, input logic v);
        for (int i = 0; i < n; i++) step(1'b0, v, 1'b0);
    endtask

    task automatic ir_scan(input logic [3:0] op);
        step(0, 1, 0); step(0, 1, 0);
        step(0, 0, 0); step(0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, i == 3, op[i]);
        step(0, 1, 0); step(0, 0, 0);
    endtask

    task automatic dr_scan(input logic [3:0] bits);
        step(0, 1, 0); step(0, 0, 0); step(0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, i == 3, bits[i]);
        step(0, 1, 0); step(0, 0, 0);
    endtask

    initial begin
        step(1, 0, 0);
        chk("reset_idcode", IDCODE_SELECT, 1);
        step(0, 0, 0);
        chk("reset_rti", TAP_STATE, 4'hC);
        tms_seq(5, 1);
        chk("tlr_from_rti", TAP_STATE, 4'hF);
        step(0, 0, 0); step(0, 1, 0);
        step(0, 0, 0); step(0, 0, 0);
        tms_seq(5, 1);
        step(0, 0, 0); step(0, 1, 0); step(0, 1, 0);
        step(0, 0, 0); step(0, 0, 0);
        step(0, 1, 0); step(0, 0, 0);
        chk("in_pauir", TAP_STATE, 4'hB);
        tms_seq(5, 1);
        step(0, 0, 0);
        ir_scan(4'h4);
        chk("usercode_sel", USERCODE_SELECT, 1);
        ir_scan(4'hF);
        dr_scan(4'b1101);
        chk("bypass_sel", BYPASS_SELECT, 1);
        ir_scan(4'h5);
        tms_seq(4, 0);
        dr_scan(4'b0110);
        tms_seq(3, 0);
        step(0, 1, 0); step(0, 1, 0);
        step(0, 0, 0); step(0, 0, 0);
        step(0, 0, 1); step(0, 0, 1);
        step(1, 0, 0);
        chk("mid_shift_rst", TAP_STATE, 4'hF);
        step(0, 0, 0);
        chk("mid_shift_ir", IDCODE_SELECT, 1);
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 199) == 0,
                 $urandom_range(0, 99) < 40,
                 1'($urandom_range(0, 1)));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
